// File: rtl/multi_light_manager.sv
// -----------------------------------------------------------------------------
// multi_light_manager
//
// Drives NUM_CHANNELS independent PWM light outputs from a single rotary
// encoder. The encoder's step pulses move the target brightness of the
// currently selected channel. A slow ramp then fades each channel's current
// brightness toward its target, one LSB per prescaler tick. A shared PWM
// counter turns each channel's duty value into a registered pulse train.
//
// Ports
//   clk_i     in   1              single rising-edge clock
//   rst_i     in   1              asynchronous active-high reset
//   inc_i     in   1              one-clock pulse: raise selected target
//   dec_i     in   1              one-clock pulse: lower selected target
//   next_i    in   1              one-clock pulse: select next channel
//   pwm_o     out  NUM_CHANNELS   registered PWM outputs
//   chan_o    out  clog2(NCH)     selected channel index
//   target_o  out  N              target brightness of the selected channel
//
// The control inputs are plain event pulses. There is no handshake: each
// clock cycle in which a pulse is high counts as exactly one event.
// -----------------------------------------------------------------------------
module multi_light_manager #(
    parameter int NUM_CHANNELS   = 4,
    parameter int PWM_VALUE_SIZE = 8,
    parameter int BRIGHTNESS_INC = 5,
    parameter int SATURATE       = 1,
    parameter int RAMP_DIV       = 1000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            inc_i,
    input  logic                            dec_i,
    input  logic                            next_i,
    output logic [NUM_CHANNELS-1:0]         pwm_o,
    output logic [$clog2(NUM_CHANNELS)-1:0] chan_o,
    output logic [PWM_VALUE_SIZE-1:0]       target_o
);

    localparam int N   = PWM_VALUE_SIZE;
    localparam int CW  = $clog2(NUM_CHANNELS);
    // A divider of 1 still needs a 1-bit register; it simply ticks every clock.
    localparam int PSW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [N-1:0]   MAX_V     = '1;
    localparam logic [N-1:0]   CNT_LAST  = {{(N-1){1'b1}}, 1'b0};  // 2^N-2
    localparam logic [N:0]     INC_W     = (N+1)'(BRIGHTNESS_INC);
    localparam logic [PSW-1:0] PS_LAST   = PSW'(RAMP_DIV - 1);
    localparam logic [CW-1:0]  CHAN_LAST = CW'(NUM_CHANNELS - 1);

    logic [N-1:0]   t_q [NUM_CHANNELS];   // target brightness
    logic [N-1:0]   c_q [NUM_CHANNELS];   // current (fading) brightness
    logic [N-1:0]   d_q [NUM_CHANNELS];   // duty latched at period start
    logic [CW-1:0]  chan_q;
    logic [PSW-1:0] ps_q;
    logic [N-1:0]   cnt_q;

    logic           ramp_tick;
    logic [N-1:0]   tgt_sel;
    logic [N:0]     sum_w;
    logic [N:0]     diff_w;
    logic [N-1:0]   tgt_next;
    logic [N-1:0]   duty_eff [NUM_CHANNELS];

    assign ramp_tick = (ps_q == PS_LAST);

    // The selected channel's next target. The extra top bit of the sum or
    // difference flags an overflow or a borrow, which decides between clamping
    // and wrapping. An inc and a dec in the same cycle cancel each other out.
    always_comb begin
        tgt_sel  = t_q[chan_q];
        sum_w    = {1'b0, tgt_sel} + INC_W;
        diff_w   = {1'b0, tgt_sel} - INC_W;
        tgt_next = tgt_sel;
        if (inc_i && !dec_i) begin
            tgt_next = (SATURATE != 0 && sum_w[N]) ? MAX_V : sum_w[N-1:0];
        end else if (dec_i && !inc_i) begin
            tgt_next = (SATURATE != 0 && diff_w[N]) ? '0 : diff_w[N-1:0];
        end
    end

    // At counter value 0 the freshly latched duty must already apply. This
    // keeps the whole period on one duty value, so a change never shortens or
    // stretches a pulse.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            duty_eff[i] = (cnt_q == '0) ? c_q[i] : d_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chan_q <= '0;
            ps_q   <= '0;
            cnt_q  <= '0;
            pwm_o  <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                t_q[i] <= '0;
                c_q[i] <= '0;
                d_q[i] <= '0;
            end
        end else begin
            ps_q  <= ramp_tick ? '0 : ps_q + 1'b1;
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

            // A step pulse that coincides with next_i still uses the old chan_q.
            t_q[chan_q] <= tgt_next;
            if (next_i) begin
                chan_q <= (chan_q == CHAN_LAST) ? '0 : chan_q + 1'b1;
            end

            for (int i = 0; i < NUM_CHANNELS; i++) begin
                // The fade always starts from the present value, so retargeting
                // mid-fade only changes the direction and never jumps.
                if (ramp_tick) begin
                    if (c_q[i] < t_q[i]) begin
                        c_q[i] <= c_q[i] + 1'b1;
                    end else if (c_q[i] > t_q[i]) begin
                        c_q[i] <= c_q[i] - 1'b1;
                    end
                end
                if (cnt_q == '0) begin
                    d_q[i] <= c_q[i];
                end
                pwm_o[i] <= (cnt_q < duty_eff[i]);
            end
        end
    end

    assign chan_o   = chan_q;
    assign target_o = tgt_sel;

endmodule

// File: tb/tb_multi_light_manager.sv
// -----------------------------------------------------------------------------
// tb_multi_light_manager
//
// This bench drives two instances of the design from one clock and one reset:
//   dut_a : N=8, INC=5, SATURATE=1, RAMP_DIV=2
//   dut_b : N=8, INC=5, SATURATE=0, RAMP_DIV=2
// A behavioural model works out the expected outputs from the edge count since
// reset. The PWM phase is edge%255, a ramp tick falls on edge%2==1, and targets
// follow integer clamp or mod-256 arithmetic. The model is compared with both
// instances on every falling edge. Directed steps also check hand-computed
// literal values.
// -----------------------------------------------------------------------------
module tb_multi_light_manager;

    localparam int NCH   = 4;
    localparam int RDIV  = 2;
    localparam int PER   = 255;
    localparam int STEP  = 5;

    logic       clk;
    logic       rst;
    logic [1:0] inc;
    logic [1:0] dec;
    logic [1:0] nxt;

    logic [3:0] pwm_a, pwm_b;
    logic [1:0] chan_a, chan_b;
    logic [7:0] tgt_a, tgt_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 0;

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_light_manager #(
        .NUM_CHANNELS(4), .PWM_VALUE_SIZE(8), .BRIGHTNESS_INC(5),
        .SATURATE(1), .RAMP_DIV(2)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .inc_i(inc[0]), .dec_i(dec[0]),
        .next_i(nxt[0]), .pwm_o(pwm_a), .chan_o(chan_a), .target_o(tgt_a)
    );

    multi_light_manager #(
        .NUM_CHANNELS(4), .PWM_VALUE_SIZE(8), .BRIGHTNESS_INC(5),
        .SATURATE(0), .RAMP_DIV(2)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .inc_i(inc[1]), .dec_i(dec[1]),
        .next_i(nxt[1]), .pwm_o(pwm_b), .chan_o(chan_b), .target_o(tgt_b)
    );

    // ---------------- behavioural model ----------------
    int m_tgt  [2][NCH];
    int m_cur  [2][NCH];
    int m_duty [2][NCH];
    int m_pwm  [2][NCH];
    int m_chan [2];
    int e_cnt;

    function automatic int adj(input int v, input int delta, input bit sat);
        int r;
        r = v + delta;
        if (sat) begin
            if (r > 255) r = 255;
            if (r < 0)   r = 0;
        end else begin
            r = (r + 256) % 256;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_cnt = 0;
            for (int d = 0; d < 2; d++) begin
                m_chan[d] = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_tgt[d][i] = 0; m_cur[d][i] = 0;
                    m_duty[d][i] = 0; m_pwm[d][i] = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (e_cnt % PER == 0) m_duty[d][i] = m_cur[d][i];
                    m_pwm[d][i] = ((e_cnt % PER) < m_duty[d][i]) ? 1 : 0;
                    if (e_cnt % RDIV == RDIV - 1) begin
                        if (m_cur[d][i] < m_tgt[d][i])      m_cur[d][i]++;
                        else if (m_cur[d][i] > m_tgt[d][i]) m_cur[d][i]--;
                    end
                end
                if (inc[d] && !dec[d])
                    m_tgt[d][m_chan[d]] = adj(m_tgt[d][m_chan[d]], STEP, d == 0);
                else if (dec[d] && !inc[d])
                    m_tgt[d][m_chan[d]] = adj(m_tgt[d][m_chan[d]], -STEP, d == 0);
                if (nxt[d]) m_chan[d] = (m_chan[d] + 1) % NCH;
            end
            e_cnt++;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_pwm(input int d);
        int v;
        v = 0;
        for (int i = 0; i < NCH; i++) v |= m_pwm[d][i] << i;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("model pwm_a",  int'(pwm_a),  exp_pwm(0));
            check("model chan_a", int'(chan_a), m_chan[0]);
            check("model tgt_a",  int'(tgt_a),  m_tgt[0][m_chan[0]]);
            check("model pwm_b",  int'(pwm_b),  exp_pwm(1));
            check("model chan_b", int'(chan_b), m_chan[1]);
            check("model tgt_b",  int'(tgt_b),  m_tgt[1][m_chan[1]]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse(input int d, input bit pi, input bit pd, input bit pn);
        inc[d] = pi; dec[d] = pd; nxt[d] = pn;
        @(negedge clk);
        inc[d] = 1'b0; dec[d] = 1'b0; nxt[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int ch, output int c);
        c = 0;
        repeat (PER) begin
            @(negedge clk);
            c += int'(pwm_a[ch]);
        end
    endtask

    // ---------------- directed stimulus ----------------
    int cnt;

    initial begin
        rst = 1'b0; inc = '0; dec = '0; nxt = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset pwm_a",  int'(pwm_a),  0);
        check("reset chan_a", int'(chan_a), 0);
        check("reset tgt_a",  int'(tgt_a),  0);
        rst = 1'b0;
        chk_on = 1'b1;

        // channel select sequence 1,2,3,0
        pulse(0, 0, 0, 1); check("next 1", int'(chan_a), 1);
        pulse(0, 0, 0, 1); check("next 2", int'(chan_a), 2);
        pulse(0, 0, 0, 1); check("next 3", int'(chan_a), 3);
        pulse(0, 0, 0, 1); check("next wrap 0", int'(chan_a), 0);

        // saturating steps on channel 0
        repeat (3) pulse(0, 1, 0, 0);
        check("3 inc", int'(tgt_a), 15);
        repeat (4) pulse(0, 0, 1, 0);
        check("4 dec clamp 0", int'(tgt_a), 0);
        pulse(0, 1, 1, 0);
        check("inc+dec hold", int'(tgt_a), 0);

        // fade channel 0 to 10 and measure the duty
        repeat (2) pulse(0, 1, 0, 0);
        check("tgt0 10", int'(tgt_a), 10);
        idle(900);
        count_high(0, cnt);
        check("duty ch0 10/255", cnt, 10);

        // channel 1 to full scale, saturating at the top
        pulse(0, 0, 0, 1);
        repeat (52) pulse(0, 1, 0, 0);
        check("clamp 255", int'(tgt_a), 255);

        // step combined with next on channel 3
        pulse(0, 0, 0, 1);
        pulse(0, 0, 0, 1);
        check("at ch3", int'(chan_a), 3);
        pulse(0, 1, 0, 1);
        check("inc+next chan", int'(chan_a), 0);
        check("inc+next T0 kept", int'(tgt_a), 10);
        repeat (3) pulse(0, 0, 0, 1);
        check("inc+next T3", int'(tgt_a), 5);

        idle(900);
        count_high(1, cnt);
        check("duty ch1 full", cnt, 255);
        count_high(2, cnt);
        check("duty ch2 zero", cnt, 0);
        count_high(3, cnt);
        check("duty ch3 5/255", cnt, 5);

        // wrap arithmetic on instance b: 103*5 = 515 = 3 mod 256
        repeat (103) pulse(1, 1, 0, 0);
        check("wrap tgt 3", int'(tgt_b), 3);
        pulse(1, 0, 1, 0);
        check("wrap dec 254", int'(tgt_b), 254);
        pulse(1, 1, 0, 0);
        check("wrap inc 3", int'(tgt_b), 3);

        // retarget channel 0 mid-period, then reset during the fade
        pulse(0, 0, 0, 1);
        idle(100);
        repeat (2) pulse(0, 1, 0, 0);
        check("tgt0 20", int'(tgt_a), 20);
        idle(6);
        inc[0] = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("async rst pwm_a",  int'(pwm_a),  0);
        check("async rst chan_a", int'(chan_a), 0);
        check("async rst tgt_a",  int'(tgt_a),  0);
        check("async rst tgt_b",  int'(tgt_b),  0);
        @(negedge clk);
        inc[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("inc in reset ignored", int'(tgt_a), 0);

        // the counters restart from 0 after reset
        repeat (2) pulse(0, 1, 0, 0);
        idle(600);
        count_high(0, cnt);
        check("duty after reset", cnt, 10);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
